sram_req_ctrl_1p128x312: RTL and testbench

- Initiator-side controller for the 128x312 single-port SRAM macro with 39-bit mask lanes.
- Converts an upstream valid/ready request channel into the macro's req/write/addr/active-low wmask/wdata strobes.
- Returns read data with a fixed-latency response valid.
- Runs a zero-fill (scrub) engine after reset, and again on demand, so the array never returns uninitialised contents.

---
 rtl/sram_1p128x312_pkg.sv | 22 ++
 rtl/sram_req_ctrl_1p128x312_init_seq.sv | 50 +++++
 rtl/sram_req_ctrl_1p128x312.sv | 105 ++++++++++
 tb/tb_sram_req_ctrl_1p128x312.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_1p128x312_pkg.sv
// Shared constants, types and controller state encoding for the 128x312 single-port SRAM.
package sram_1p128x312_pkg;

  localparam int Depth           = 128;
  localparam int Width           = 312;
  localparam int DataBitsPerMask = 39;
  localparam int MaskWidth       = Width / DataBitsPerMask;
  localparam int AddrWidth       = $clog2(Depth);

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [Width-1:0]     data_t;
  typedef logic [MaskWidth-1:0] mask_t;

  localparam data_t InitValue = '0;
  localparam addr_t LastAddr  = addr_t'(Depth - 1);

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/sram_req_ctrl_1p128x312_init_seq.sv
// Scrub sequencer: walks every address once after reset or on request, then reports done.
module sram_init_seq
  import sram_1p128x312_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  init_start_i,
  output logic  init_active_o,
  output addr_t init_addr_o,
  output logic  init_done_o
);

  ctrl_state_e state_q, state_d;
  addr_t       cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + addr_t'(1);
        if (cnt_q == LastAddr) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      READY: begin
        if (init_start_i) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
    endcase
  end

  assign init_active_o = (state_q == INIT);
  assign init_done_o   = (state_q == READY);
  assign init_addr_o   = cnt_q;

endmodule

// File: rtl/sram_req_ctrl_1p128x312.sv
// Request controller for the 128x312 SRAM: scrub muxing, macro strobes and read response path.
// Optional SRAM_REQ_CTRL_RDATA_REG_EN adds a macro read-data capture stage (latency 2).
module sram_req_ctrl_1p128x312
  import sram_1p128x312_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_write_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [MaskWidth-1:0] req_lane_en_i,
  input  logic [Width-1:0]     req_wdata_i,
  output logic                 rsp_valid_o,
  output logic [Width-1:0]     rsp_rdata_o,
  input  logic                 init_start_i,
  output logic                 init_done_o,
  output logic                 sram_req_o,
  output logic                 sram_write_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [MaskWidth-1:0] sram_wmask_o,
  output logic [Width-1:0]     sram_wdata_o,
  input  logic [Width-1:0]     sram_rdata_i
);

  logic  init_active;
  logic  init_done;
  addr_t init_addr;
  logic  accept;
  logic  rd_vld_p0;

  sram_init_seq u_init_seq (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .init_start_i  (init_start_i),
    .init_active_o (init_active),
    .init_addr_o   (init_addr),
    .init_done_o   (init_done)
  );

  assign req_ready_o = init_done;
  assign init_done_o = init_done;
  assign accept      = req_valid_i & init_done;
  assign rd_vld_p0   = accept & ~req_write_i;

  // The sequencer sits in INIT while reset is held, so its strobes are masked by rst_i.
  always_comb begin
    sram_req_o   = 1'b0;
    sram_write_o = 1'b0;
    sram_addr_o  = init_addr;
    sram_wmask_o = '1;
    sram_wdata_o = InitValue;
    if (init_active) begin
      sram_req_o   = ~rst_i;
      sram_write_o = ~rst_i;
      sram_wmask_o = {MaskWidth{rst_i}};
    end else begin
      sram_req_o   = accept & ~(req_write_i & ~|req_lane_en_i);
      sram_write_o = req_write_i;
      sram_addr_o  = req_addr_i;
      sram_wmask_o = ~req_lane_en_i;
      sram_wdata_o = req_wdata_i;
    end
  end

`ifdef SRAM_REQ_CTRL_RDATA_REG_EN
  logic  rd_vld_p1;
  logic  rsp_vld_p2;
  data_t rdata_p2;

  // p1: macro data valid; p2: captured data presented with the response strobe
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_vld_p1  <= 1'b0;
      rsp_vld_p2 <= 1'b0;
      rdata_p2   <= '0;
    end else begin
      rd_vld_p1  <= rd_vld_p0;
      rsp_vld_p2 <= rd_vld_p1;
      if (rd_vld_p1) rdata_p2 <= sram_rdata_i;
    end
  end

  assign rsp_valid_o = rsp_vld_p2;
  assign rsp_rdata_o = rdata_p2;
`else
  logic  rsp_vld_p1;
  data_t rdata_hold_q;

  // p1: macro data is only valid this cycle, so it is forwarded once and then held.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_vld_p1   <= 1'b0;
      rdata_hold_q <= '0;
    end else begin
      rsp_vld_p1   <= rd_vld_p0;
      rdata_hold_q <= rsp_rdata_o;
    end
  end

  assign rsp_valid_o = rsp_vld_p1;
  assign rsp_rdata_o = rsp_vld_p1 ? sram_rdata_i : rdata_hold_q;
`endif

endmodule

// File: tb/tb_sram_req_ctrl_1p128x312.sv
// Scoreboard bench for sram_req_ctrl_1p128x312 with a behavioural 128x312 masked SRAM.
module tb_sram_req_ctrl_1p128x312;

`ifdef SRAM_REQ_CTRL_RDATA_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_i;
  logic         req_valid_i, req_ready_o, req_write_i;
  logic [6:0]   req_addr_i;
  logic [7:0]   req_lane_en_i;
  logic [311:0] req_wdata_i;
  logic         rsp_valid_o;
  logic [311:0] rsp_rdata_o;
  logic         init_start_i, init_done_o;
  logic         sram_req_o, sram_write_o;
  logic [6:0]   sram_addr_o;
  logic [7:0]   sram_wmask_o;
  logic [311:0] sram_wdata_o;
  logic [311:0] sram_rdata_i;

  always #5 clk = ~clk;

  sram_req_ctrl_1p128x312 dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_write_i   (req_write_i),
    .req_addr_i    (req_addr_i),
    .req_lane_en_i (req_lane_en_i),
    .req_wdata_i   (req_wdata_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_rdata_o   (rsp_rdata_o),
    .init_start_i  (init_start_i),
    .init_done_o   (init_done_o),
    .sram_req_o    (sram_req_o),
    .sram_write_o  (sram_write_o),
    .sram_addr_o   (sram_addr_o),
    .sram_wmask_o  (sram_wmask_o),
    .sram_wdata_o  (sram_wdata_o),
    .sram_rdata_i  (sram_rdata_i)
  );

  // Macro model: masked write, read data valid for one cycle after the request, junk otherwise.
  logic [311:0] mem [128];
  logic [311:0] junk;
  initial begin
    junk = {39{8'h69}};
    for (int i = 0; i < 128; i++) mem[i] = {39{8'hC3}};
  end

  always @(posedge clk) begin
    if (sram_req_o && sram_write_o) begin
      for (int l = 0; l < 8; l++)
        if (!sram_wmask_o[l]) mem[sram_addr_o][l*39 +: 39] <= sram_wdata_o[l*39 +: 39];
      sram_rdata_i <= junk;
    end else if (sram_req_o) begin
      sram_rdata_i <= mem[sram_addr_o];
    end else begin
      sram_rdata_i <= junk;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input bit ok, input logic [311:0] act, input logic [311:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    logic [311:0] d;
    int           c;
  } exp_t;
  exp_t q[$];
  exp_t m_e;

  always @(negedge clk) begin
    if (!rst_i && rsp_valid_o) begin
      if (q.size() == 0) begin
        chk("rsp_unexpected", 1'b0, rsp_rdata_o, 312'd0);
      end else begin
        m_e = q.pop_front();
        chk("rsp_data", rsp_rdata_o === m_e.d, rsp_rdata_o, m_e.d);
        chk("rsp_latency", cyc == m_e.c, 312'(cyc), 312'(m_e.c));
      end
    end
  end

  task automatic idle();
    @(negedge clk);
    req_valid_i   = 1'b0;
    req_write_i   = 1'b0;
    req_lane_en_i = 8'h00;
    init_start_i  = 1'b0;
    #1;
  endtask

  task automatic issue(input string nm, input bit wr, input logic [6:0] a, input logic [7:0] lane,
                       input logic [311:0] d, input bit start, input logic [311:0] exp);
    logic [17:0] s_act, s_exp;
    @(negedge clk);
    req_valid_i   = 1'b1;
    req_write_i   = wr;
    req_addr_i    = a;
    req_lane_en_i = lane;
    req_wdata_i   = d;
    init_start_i  = start;
    #1;
    s_act = {req_ready_o, sram_req_o, sram_write_o, sram_addr_o, sram_wmask_o};
    s_exp = {1'b1, !(wr && lane == 8'h00), wr, a, ~lane};
    chk({nm, "_strobe"}, s_act === s_exp, 312'(s_act), 312'(s_exp));
    if (wr) chk({nm, "_wdata"}, sram_wdata_o === d, sram_wdata_o, d);
    else q.push_back('{exp, cyc + LAT});
  endtask

  task automatic check_reset(input string nm);
    logic [19:0] c_act;
    c_act = {req_ready_o, rsp_valid_o, init_done_o, sram_req_o, sram_write_o, sram_addr_o, sram_wmask_o};
    chk({nm, "_ctrl"}, c_act === {5'b0, 7'd0, 8'hFF}, 312'(c_act), 312'({5'b0, 7'd0, 8'hFF}));
    chk({nm, "_data"}, rsp_rdata_o === 312'd0 && sram_wdata_o === 312'd0,
        rsp_rdata_o | sram_wdata_o, 312'd0);
  endtask

  // Entered one step after the edge that shows scrub address 0; returns one step after READY.
  task automatic check_scrub(input string nm);
    int bad = 0;
    for (int i = 0; i < 128; i++) begin
      if (!(sram_req_o === 1'b1 && sram_write_o === 1'b1 && sram_addr_o === 7'(i) &&
            sram_wmask_o === 8'h00 && sram_wdata_o === 312'd0 &&
            req_ready_o === 1'b0 && init_done_o === 1'b0)) bad++;
      @(negedge clk);
      #1;
    end
    chk({nm, "_writes"}, bad == 0, 312'(bad), 312'd0);
    chk({nm, "_done"}, init_done_o === 1'b1 && req_ready_o === 1'b1 && sram_req_o === 1'b0,
        312'({init_done_o, req_ready_o, sram_req_o}), 312'(3'b110));
  endtask

  logic [311:0] pa, pb, pc, l0, mix;

  initial begin
    pa  = {39{8'hA5}};
    pb  = {39{8'h3C}};
    pc  = {39{8'h5A}};
    l0  = {273'd0, {39{1'b1}}};
    mix = {pb[311:273], pa[272:0]};

    rst_i = 1'b1;
    req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0;
    req_lane_en_i = '0; req_wdata_i = '0; init_start_i = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    check_scrub("scrub0");

    issue("rd5", 1'b0, 7'd5, 8'h00, '0, 1'b0, 312'd0);
    issue("wr3_lane0", 1'b1, 7'd3, 8'h01, {312{1'b1}}, 1'b0, '0);
    issue("rd3", 1'b0, 7'd3, 8'h00, '0, 1'b0, l0);

    issue("wr0", 1'b1, 7'd0, 8'hFF, pa, 1'b0, '0);
    issue("wr1", 1'b1, 7'd1, 8'hFF, pb, 1'b0, '0);
    issue("wr2", 1'b1, 7'd2, 8'hFF, pc, 1'b0, '0);
    issue("rd0", 1'b0, 7'd0, 8'h00, '0, 1'b0, pa);
    issue("rd1", 1'b0, 7'd1, 8'h00, '0, 1'b0, pb);
    issue("rd2", 1'b0, 7'd2, 8'h00, '0, 1'b0, pc);
    idle();
    repeat (LAT + 1) @(negedge clk);
    #1;
    chk("rsp_hold", rsp_rdata_o === pc && rsp_valid_o === 1'b0, rsp_rdata_o, pc);

    issue("wr9", 1'b1, 7'd9, 8'hFF, pa, 1'b0, '0);
    issue("raw9", 1'b0, 7'd9, 8'h00, '0, 1'b0, pa);
    issue("wr9_lane7", 1'b1, 7'd9, 8'h80, pb, 1'b0, '0);
    issue("raw9_mix", 1'b0, 7'd9, 8'h00, '0, 1'b0, mix);

    issue("wr3_nolane", 1'b1, 7'd3, 8'h00, pb, 1'b0, '0);
    issue("rd3_again", 1'b0, 7'd3, 8'h00, '0, 1'b0, l0);

    issue("wr7", 1'b1, 7'd7, 8'hFF, pc, 1'b0, '0);
    issue("rd7_start", 1'b0, 7'd7, 8'h00, '0, 1'b1, pc);
    idle();
    chk("done_drop", init_done_o === 1'b0 && req_ready_o === 1'b0,
        312'({init_done_o, req_ready_o}), 312'd0);
    check_scrub("scrub1");
    issue("rd7_scrubbed", 1'b0, 7'd7, 8'h00, '0, 1'b0, 312'd0);
    issue("wr9_b", 1'b1, 7'd9, 8'hFF, pa, 1'b0, '0);
    issue("rd9_b", 1'b0, 7'd9, 8'h00, '0, 1'b0, pa);
    idle();
    repeat (LAT + 1) @(negedge clk);

    @(negedge clk);
    init_start_i = 1'b1;
    #1;
    idle();
    repeat (60) @(negedge clk);
    #1;
    chk("scrub_at_60", sram_addr_o === 7'd60 && sram_req_o === 1'b1, 312'(sram_addr_o), 312'd60);
    rst_i = 1'b1;
    #1;
    check_reset("reset_mid");
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    #1;
    check_scrub("scrub2");
    issue("rd9_after", 1'b0, 7'd9, 8'h00, '0, 1'b0, 312'd0);

    idle();
    repeat (LAT + 3) @(negedge clk);
    chk("queue_empty", q.size() == 0, 312'(q.size()), 312'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
